// File: rtl/cordic_iterator_if.sv
`timescale 1ns/1ps
// cordic_iterator_if: operand/result bundle with valid/ready handshakes on both sides.
// Latency: none (wires only).
// Backpressure: o_ready gates operands, i_ready gates results.
interface cordic_iterator_if #(
   parameter int p_WIDTH = 32
);
   logic                      i_valid;
   logic                      o_ready;
   logic signed [p_WIDTH-1:0] i_x;
   logic signed [p_WIDTH-1:0] i_y;
   logic signed [p_WIDTH-1:0] i_z;
   logic                      i_mode;
   logic                      o_valid;
   logic                      i_ready;
   logic signed [p_WIDTH-1:0] o_x;
   logic signed [p_WIDTH-1:0] o_y;
   logic signed [p_WIDTH-1:0] o_z;

   // CORDIC block side
   modport slave (
      input  i_valid, i_x, i_y, i_z, i_mode, i_ready,
      output o_ready, o_valid, o_x, o_y, o_z
   );

   // Operand producer / result consumer side
   modport master (
      output i_valid, i_x, i_y, i_z, i_mode, i_ready,
      input  o_ready, o_valid, o_x, o_y, o_z
   );
endinterface

// File: rtl/cordic_iterator.sv
`timescale 1ns/1ps
// cordic_iterator: iterative CORDIC rotator/vectorer, one micro-rotation per cycle.
// Latency: p_ITER cycles from accept to o_valid (p_ITER+1 with CORDIC_GAIN_COMP_EN).
// Backpressure: result held in DONE until i_ready; operands taken only in IDLE.
// Optional macro CORDIC_GAIN_COMP_EN adds a one-cycle gain-compensation (COMP) step.
module cordic_iterator #(
   parameter int p_WIDTH = 32,
   parameter int p_ITER  = 16
) (
   input logic              i_clk,
   input logic              i_reset,
   cordic_iterator_if.slave bus
);
   // Counter wide enough for 0..p_ITER-1; the ROM is padded to a power of two
   // so every counter value indexes a real entry.
   localparam int            CW   = (p_ITER > 1) ? $clog2(p_ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(p_ITER - 1);

`ifdef CORDIC_GAIN_COMP_EN
   typedef enum logic [1:0] {IDLE, RUN, COMP, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

   state_t state;
   state_t state_nxt;

   logic signed [p_WIDTH-1:0] x;
   logic signed [p_WIDTH-1:0] y;
   logic signed [p_WIDTH-1:0] z;
   logic                      mode;
   logic [CW-1:0]             cnt;

   logic signed [p_WIDTH-1:0] x_sh;
   logic signed [p_WIDTH-1:0] y_sh;
   logic signed [p_WIDTH-1:0] x_rot;
   logic signed [p_WIDTH-1:0] y_rot;
   logic signed [p_WIDTH-1:0] z_rot;
   logic                      dir_pos;

   // Angle ROM: floor(atan(2^-i) / pi * 2^(p_WIDTH-1)); full scale of z is 2*pi.
   function automatic logic [p_WIDTH-1:0] atan_entry(input int idx);
      real pi_r;
      real a;
      pi_r = 4.0 * $atan(1.0);
      a    = $atan($pow(2.0, -1.0 * real'(idx))) / pi_r * $pow(2.0, real'(p_WIDTH - 1));
      return p_WIDTH'(longint'($floor(a)));
   endfunction

   logic signed [p_WIDTH-1:0] lut [2**CW];

   for (genvar g = 0; g < 2**CW; g++) begin : g_lut
      assign lut[g] = atan_entry(g);
   end

`ifdef CORDIC_GAIN_COMP_EN
   // Inverse CORDIC gain, rounded to the Q(p_WIDTH-1) grid.
   localparam real c_GAIN_R = 0.607252935 * (2.0 ** (p_WIDTH - 1));

   logic signed [p_WIDTH-1:0]   gain;
   logic signed [2*p_WIDTH-1:0] x_prod;
   logic signed [2*p_WIDTH-1:0] y_prod;
   logic signed [p_WIDTH-1:0]   x_cmp;
   logic signed [p_WIDTH-1:0]   y_cmp;

   assign gain   = p_WIDTH'(longint'(c_GAIN_R));
   assign x_prod = x * gain;
   assign y_prod = y * gain;
   assign x_cmp  = p_WIDTH'(x_prod >>> (p_WIDTH - 1));
   assign y_cmp  = p_WIDTH'(y_prod >>> (p_WIDTH - 1));
`endif

   // Micro-rotation for the current iteration: d=+1 drives z (rotation) or y (vectoring) toward 0.
   always_comb begin
      x_sh    = x >>> cnt;
      y_sh    = y >>> cnt;
      dir_pos = mode ? ~z[p_WIDTH-1] : y[p_WIDTH-1];
      x_rot   = dir_pos ? (x - y_sh)     : (x + y_sh);
      y_rot   = dir_pos ? (y + x_sh)     : (y - x_sh);
      z_rot   = dir_pos ? (z - lut[cnt]) : (z + lut[cnt]);
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt   = state;
      bus.o_ready = 1'b0;
      bus.o_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.o_ready = 1'b1;
            if (bus.i_valid) state_nxt = RUN;
         end
         RUN: begin
`ifdef CORDIC_GAIN_COMP_EN
            if (cnt == LAST) state_nxt = COMP;
`else
            if (cnt == LAST) state_nxt = DONE;
`endif
         end
`ifdef CORDIC_GAIN_COMP_EN
         COMP: state_nxt = DONE;
`endif
         DONE: begin
            bus.o_valid = 1'b1;
            if (bus.i_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch operands in IDLE, iterate in RUN, scale in COMP, hold otherwise.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         x    <= '0;
         y    <= '0;
         z    <= '0;
         mode <= 1'b0;
         cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  x    <= bus.i_x;
                  y    <= bus.i_y;
                  z    <= bus.i_z;
                  mode <= bus.i_mode;
                  cnt  <= '0;
               end
            end
            RUN: begin
               x   <= x_rot;
               y   <= y_rot;
               z   <= z_rot;
               cnt <= cnt + CW'(1);
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
               x <= x_cmp;
               y <= y_cmp;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.o_x = x;
   assign bus.o_y = y;
   assign bus.o_z = z;
endmodule

// File: doc/cordic_iterator.md
CORDIC_ITERATOR -- requirements
Module: cordic_iterator

Interface
- REQ-001: Parameter p_WIDTH, default 32: datapath width of x, y and z in bits.
- REQ-002: Parameter p_ITER, default 16: micro-rotations per operation, legal range 1..p_WIDTH-1.
- REQ-003: The block SHALL use one clock and a synchronous, active-high reset.
- REQ-004: i_clk  in  1  clock; all state updates on the rising edge.
- REQ-005: i_reset  in  1  synchronous active-high reset.
- REQ-006: i_valid  in  1  operand valid.
- REQ-007: o_ready  out  1  block can accept operands.
- REQ-008: i_x, i_y, i_z  in  p_WIDTH each  signed operands.
- REQ-009: i_mode  in  1  1 = rotation (drive z to 0), 0 = vectoring (drive y to 0).
- REQ-010: o_valid  out  1  result valid.
- REQ-011: i_ready  in  1  downstream accepts the result.
- REQ-012: o_x, o_y, o_z  out  p_WIDTH each  signed results.

Function
- REQ-013: States are IDLE, RUN and DONE, plus COMP when the macro in REQ-024 is defined.
- REQ-014: IDLE: o_ready=1, o_valid=0; on i_valid=1 the block SHALL latch x, y, z and mode, clear the iteration counter i, and go to RUN.
- REQ-015: RUN: one micro-rotation per cycle, then i increments; after i=p_ITER-1 the block goes to DONE (or to COMP when the REQ-024 macro is defined).
- REQ-016: Direction d SHALL be +1 if z>=0, else -1, in rotation mode; and +1 if y<0, else -1, in vectoring mode.
- REQ-017: Update: x'=x-d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*LUT[i]; shifts are arithmetic, and sums wrap modulo 2^p_WIDTH with no saturation.
- REQ-018: LUT SHALL be an internal ROM with LUT[i]=floor(atan(2^-i)*2^(p_WIDTH-1)/pi), so full scale is 2*pi; LUT[0]=0x20000000 for p_WIDTH=32.
- REQ-019: DONE: o_valid=1 and o_x, o_y, o_z SHALL be held stable until i_ready=1, then the block goes to IDLE; o_ready=0 in RUN, COMP and DONE.
- REQ-020: i_valid outside IDLE SHALL be ignored, including when i_ready and i_valid are both high in DONE; no bypass path exists.
- REQ-021: Latency: with operands accepted at edge T, o_valid SHALL be high after edge T+p_ITER (T+p_ITER+1 when the REQ-024 macro is defined); minimum initiation interval is p_ITER+2 cycles.
- REQ-022: o_x, o_y and o_z SHALL be driven from registers only; their value outside DONE is don't-care.

Reset
- REQ-023: While i_reset=1, state SHALL be IDLE, i=0, and o_valid=0, o_ready=1, o_x=o_y=o_z=0 after the edge; reset in any state, including mid-RUN, SHALL abandon the operation without emitting a result.

Configuration
- REQ-024: When macro CORDIC_GAIN_COMP_EN is defined, COMP state SHALL take one cycle to set x=(x*K)>>>(p_WIDTH-1) and y=(y*K)>>>(p_WIDTH-1), with K=round(0.607252935*2^(p_WIDTH-1)) (0x4DBA76D4 at 32 bits), leaving z unchanged.
- REQ-025: Without CORDIC_GAIN_COMP_EN, COMP and the multipliers SHALL be absent, and x and y SHALL carry CORDIC gain of about 1.6468.

Verification (p_WIDTH=32, p_ITER=16; tolerance of ±2^17 on results)
- REQ-026: Rotation, macro off: x=652032874, y=0, z=0x20000000, mode=1 -> o_x ≈ o_y ≈ 759250125, o_z ≈ 0.
- REQ-027: Vectoring, macro off: x=y=0x10000000, z=0, mode=0 -> o_y ≈ 0, o_z ≈ 0x20000000.
- REQ-028: Latency and backpressure: accept at edge T -> o_valid high after T+16; holding i_ready=0 for 5 cycles keeps outputs stable and o_ready=0; i_valid pulsed during this window is not accepted.
- REQ-029: Reset mid-operation: assert i_reset at iteration 7 -> the next cycle shows o_ready=1, o_valid=0 and zero outputs, and no o_valid follows.
- REQ-030: Macro on: x=0x40000000, y=0, z=0, mode=1 -> o_x ≈ 0x40000000, o_y ≈ 0, with o_valid high after T+17.
- REQ-031: Back-to-back: second i_valid held from the cycle after the first result handshake -> accepted in IDLE, and the second result is correct.
